store_buffer: RTL and testbench

Posted-write buffer between the CPU memory stage and the byte-addressed, big-endian 64-bit data memory. Stores are accepted into a small FIFO and drained to memory one per cycle whenever the memory port is idle. Loads own the port with priority and are forwarded from the buffer on an exact doubleword match. A load stalls on a partial overlap until the conflicting stores have drained.

---
 rtl/store_buffer_pkg.sv | 13 +
 rtl/sb_addr_match.sv | 27 ++
 rtl/store_buffer.sv | 117 +++++++++++
 tb/tb_store_buffer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-write store buffer.
// Entries hold one big-endian doubleword and its byte address.
package store_buffer_pkg;

    localparam int SB_DEPTH    = 4;
    localparam int DWORD_BYTES = 8;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_addr_match.sv
// Per-entry comparator: exact doubleword hit or partial byte overlap.
// 65-bit sums keep the range test free of wraparound at the top of memory.
module sb_addr_match
    import store_buffer_pkg::*;
(
    input  logic        valid_i,
    input  logic [63:0] entry_addr_i,
    input  logic [63:0] load_addr_i,
    output logic        hit_o,
    output logic        overlap_o
);

    logic [64:0] ea;
    logic [64:0] la;
    logic        eq;
    logic        span;

    assign ea   = {1'b0, entry_addr_i};
    assign la   = {1'b0, load_addr_i};
    assign eq   = (entry_addr_i == load_addr_i);
    assign span = (la < ea + 65'(DWORD_BYTES)) &&
                  (ea < la + 65'(DWORD_BYTES));

    assign hit_o     = valid_i && eq;
    assign overlap_o = valid_i && span && !eq;

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the memory stage and data memory.
// Loads own the port, forward on exact match and stall on partial overlap.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       StoreValid_i,
    input  logic [63:0]                StoreAddress_i,
    input  logic [63:0]                StoreData_i,
    output logic                       StoreReady_o,
    input  logic                       LoadValid_i,
    input  logic [63:0]                LoadAddress_i,
    output logic [63:0]                LoadData_o,
    output logic                       LoadStall_o,
    output logic [63:0]                MemAddress_o,
    output logic [63:0]                MemWriteData_o,
    output logic                       MemoryRead_o,
    output logic                       MemoryWrite_o,
    input  logic [63:0]                MemReadData_i,
    output logic                       Empty_o,
    output logic [$clog2(DEPTH+1)-1:0] Count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    sb_entry_t         ent_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     off [DEPTH];
    logic [DEPTH-1:0]  live, hit, ovl;
    logic [PW-1:0]     idx;
    logic              fwd_hit;
    logic [63:0]       fwd_data;
    logic              push, pop;

    // Slot g is occupied when its distance from head is below Count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign off[g]  = PW'(g) - head_q;
        assign live[g] = CW'(off[g]) < count_q;
        sb_addr_match u_match (
            .valid_i      (live[g]),
            .entry_addr_i (ent_q[g].addr),
            .load_addr_i  (LoadAddress_i),
            .hit_o        (hit[g]),
            .overlap_o    (ovl[g])
        );
    end

    // Youngest hit wins: walk from tail-1 back toward head.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail_q - PW'(k) - PW'(1);
            if (!fwd_hit && hit[idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_q[idx].data;
            end
        end
    end

    assign StoreReady_o = (count_q != CW'(DEPTH));
    assign push         = StoreValid_i && StoreReady_o;

    always_comb begin
        MemoryRead_o   = 1'b0;
        MemoryWrite_o  = 1'b0;
        MemAddress_o   = '0;
        MemWriteData_o = '0;
        LoadData_o     = '0;
        LoadStall_o    = 1'b0;
        pop            = 1'b0;
        if (LoadValid_i && !(|ovl)) begin
            MemoryRead_o = 1'b1;
            MemAddress_o = LoadAddress_i;
            LoadData_o   = fwd_hit ? fwd_data : MemReadData_i;
        end else begin
            LoadStall_o = LoadValid_i;
            if (count_q != '0) begin
                MemoryWrite_o  = 1'b1;
                MemAddress_o   = ent_q[head_q].addr;
                MemWriteData_o = ent_q[head_q].data;
                pop            = 1'b1;
            end
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) ent_q[tail_q] <= '{addr: StoreAddress_i, data: StoreData_i};
        end
    end

    assign Empty_o = (count_q == '0);
    assign Count_o = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a big-endian byte memory model.
// Table rows are applied one per cycle; corner cases follow by hand.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sv = 1'b0, lv = 1'b0;
    logic [63:0] sa = '0, sd = '0, la = '0;
    logic        s_rdy, l_stall, m_rd, m_wr, empty;
    logic [63:0] l_data, m_addr, m_wdata, m_rdata;
    logic [2:0]  count;

    logic [7:0]  mem [0:255] = '{default: 8'h00};
    logic [63:0] wa_q [$];
    logic [63:0] wd_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .StoreValid_i(sv), .StoreAddress_i(sa), .StoreData_i(sd),
        .StoreReady_o(s_rdy),
        .LoadValid_i(lv), .LoadAddress_i(la),
        .LoadData_o(l_data), .LoadStall_o(l_stall),
        .MemAddress_o(m_addr), .MemWriteData_o(m_wdata),
        .MemoryRead_o(m_rd), .MemoryWrite_o(m_wr),
        .MemReadData_i(m_rdata),
        .Empty_o(empty), .Count_o(count)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_rdata = '0;
        for (int b = 0; b < 8; b++)
            m_rdata = {m_rdata[55:0], mem[8'(m_addr + 64'(b))]};
    end

    always @(posedge clk) begin
        if (m_wr) begin
            for (int b = 0; b < 8; b++)
                mem[8'(m_addr + 64'(b))] <= m_wdata[63-8*b -: 8];
            wa_q.push_back(m_addr);
            wd_q.push_back(m_wdata);
        end
    end

    typedef struct {
        bit          sv;
        logic [63:0] sa, sd;
        bit          lv;
        logic [63:0] la;
        bit          rdy, stl, mrd, mwr;
        logic [63:0] ma, ld;
        int          cnt;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t v(bit s_v, logic [63:0] s_a, logic [63:0] s_d,
                               bit l_v, logic [63:0] l_a,
                               bit rdy, bit stl, bit mrd, bit mwr,
                               logic [63:0] ma, logic [63:0] ld, int cnt);
        vec_t r;
        r.sv = s_v; r.sa = s_a; r.sd = s_d; r.lv = l_v; r.la = l_a;
        r.rdy = rdy; r.stl = stl; r.mrd = mrd; r.mwr = mwr;
        r.ma = ma; r.ld = ld; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(bit s_v, logic [63:0] s_a, logic [63:0] s_d,
                         bit l_v, logic [63:0] l_a);
        @(negedge clk);
        sv = s_v; sa = s_a; sd = s_d; lv = l_v; la = l_a;
        #1;
    endtask

    logic [63:0] exp_wa [9];
    logic [63:0] exp_wd [9];
    logic [63:0] rd8;

    initial begin
        tbl[0]  = v(1, 64'h08, 64'h1122334455667788, 0, 0, 1,0,0,0, 0, 0, 0);
        tbl[1]  = v(0, 0, 0, 0, 0,             1,0,0,1, 64'h08, 0, 1);
        tbl[2]  = v(1, 64'h20, 64'hAA, 0, 0,   1,0,0,0, 0, 0, 0);
        tbl[3]  = v(0, 0, 0, 1, 64'h20,        1,0,1,0, 64'h20, 64'hAA, 1);
        tbl[4]  = v(0, 0, 0, 0, 0,             1,0,0,1, 64'h20, 0, 1);
        tbl[5]  = v(1, 64'h20, 64'h1, 0, 0,    1,0,0,0, 0, 0, 0);
        tbl[6]  = v(1, 64'h20, 64'h2, 1, 64'h30, 1,0,1,0, 64'h30, 0, 1);
        tbl[7]  = v(0, 0, 0, 1, 64'h20,        1,0,1,0, 64'h20, 64'h2, 2);
        tbl[8]  = v(0, 0, 0, 0, 0,             1,0,0,1, 64'h20, 0, 2);
        tbl[9]  = v(0, 0, 0, 0, 0,             1,0,0,1, 64'h20, 0, 1);
        tbl[10] = v(1, 64'h18, 64'hDEADBEEF, 0, 0, 1,0,0,0, 0, 0, 0);
        tbl[11] = v(0, 0, 0, 1, 64'h1C,        1,1,0,1, 64'h18, 0, 1);
        tbl[12] = v(0, 0, 0, 1, 64'h1C,        1,0,1,0, 64'h1C, 64'hDEADBEEF00000000, 0);
        tbl[13] = v(1, 64'h40, 64'h40, 1, 64'hC0, 1,0,1,0, 64'hC0, 0, 0);
        tbl[14] = v(1, 64'h48, 64'h48, 1, 64'hC0, 1,0,1,0, 64'hC0, 0, 1);
        tbl[15] = v(1, 64'h50, 64'h50, 1, 64'hC0, 1,0,1,0, 64'hC0, 0, 2);
        tbl[16] = v(1, 64'h58, 64'h58, 1, 64'hC0, 1,0,1,0, 64'hC0, 0, 3);
        tbl[17] = v(1, 64'h60, 64'h60, 1, 64'hC0, 0,0,1,0, 64'hC0, 0, 4);
        tbl[18] = v(0, 0, 0, 0, 0,             0,0,0,1, 64'h40, 0, 4);
        tbl[19] = v(0, 0, 0, 0, 0,             1,0,0,1, 64'h48, 0, 3);
        tbl[20] = v(0, 0, 0, 0, 0,             1,0,0,1, 64'h50, 0, 2);
        tbl[21] = v(0, 0, 0, 0, 0,             1,0,0,1, 64'h58, 0, 1);
        tbl[22] = v(0, 0, 0, 0, 0,             1,0,0,0, 0, 0, 0);

        exp_wa = '{64'h08, 64'h20, 64'h20, 64'h20, 64'h18,
                   64'h40, 64'h48, 64'h50, 64'h58};
        exp_wd = '{64'h1122334455667788, 64'hAA, 64'h1, 64'h2,
                   64'hDEADBEEF, 64'h40, 64'h48, 64'h50, 64'h58};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(s_rdy), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_mwrite", 64'(m_wr), 64'd0);
        chk("rst_stall", 64'(l_stall), 64'd0);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lv, tbl[i].la);
            chk($sformatf("r%0d_ready", i), 64'(s_rdy), 64'(tbl[i].rdy));
            chk($sformatf("r%0d_stall", i), 64'(l_stall), 64'(tbl[i].stl));
            chk($sformatf("r%0d_mread", i), 64'(m_rd), 64'(tbl[i].mrd));
            chk($sformatf("r%0d_mwrite", i), 64'(m_wr), 64'(tbl[i].mwr));
            chk($sformatf("r%0d_maddr", i), m_addr, tbl[i].ma);
            chk($sformatf("r%0d_ldata", i), l_data, tbl[i].ld);
            chk($sformatf("r%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("r%0d_empty", i), 64'(empty), 64'(tbl[i].cnt == 0));
        end

        rd8 = '0;
        for (int b = 8; b < 16; b++) rd8 = {rd8[55:0], mem[b]};
        chk("mem_0x8_bytes", rd8, 64'h1122334455667788);

        chk("wlog_len", 64'(wa_q.size()), 64'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < wa_q.size()) begin
                chk($sformatf("wlog%0d_addr", i), wa_q[i], exp_wa[i]);
                chk($sformatf("wlog%0d_data", i), wd_q[i], exp_wd[i]);
            end
        end

        // Reset while draining: remaining stores must never reach memory.
        drive(1, 64'h80, 64'h80, 1, 64'hC0);
        drive(1, 64'h88, 64'h88, 1, 64'hC0);
        drive(1, 64'h90, 64'h90, 1, 64'hC0);
        drive(0, 0, 0, 0, 0);
        chk("rs_count3", 64'(count), 64'd3);
        chk("rs_drain0", m_addr, 64'h80);
        drive(0, 0, 0, 0, 0);
        chk("rs_mid_mwrite", 64'(m_wr), 64'd1);
        chk("rs_mid_addr", m_addr, 64'h88);
        rst = 1'b1;
        #1;
        chk("rs_count", 64'(count), 64'd0);
        chk("rs_empty", 64'(empty), 64'd1);
        chk("rs_mwrite", 64'(m_wr), 64'd0);
        chk("rs_ready", 64'(s_rdy), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) drive(0, 0, 0, 0, 0);
        chk("rs_wlog_len", 64'(wa_q.size()), 64'd10);
        if (wa_q.size() == 10) chk("rs_wlog_last", wa_q[9], 64'h80);
        chk("rs_final_empty", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
